// File: rtl/tetris_pkg.sv
// Shared types and grid helpers for the Tetris playfield controller.
// Grids are flattened row-major: cell (r,c) lives at bit r*cols + c.
package tetris_pkg;

  localparam int DEF_ROWS   = 22;
  localparam int DEF_COLS   = 10;
  localparam int DEF_LINE_W = 16;
  localparam int MAX_CELLS  = 1024;

  typedef enum logic [2:0] {SPAWN, FALL, LOCK, CLEAR, OVER} game_state_e;

  typedef logic [MAX_CELLS-1:0] grid_t;

  function automatic grid_t col_mask(input int cols, input int col);
    grid_t m;
    m = '0;
    for (int i = 0; i < MAX_CELLS; i++) m[i] = ((i % cols) == col);
    return m;
  endfunction

  function automatic grid_t row_mask(input int cols, input int row);
    grid_t m;
    m = '0;
    for (int i = 0; i < MAX_CELLS; i++) m[i] = ((i / cols) == row);
    return m;
  endfunction

  // Callers must zero-extend narrower grids so the unused upper cells stay empty.
  function automatic grid_t shift_down(input grid_t g, input int cols);
    return g << cols;
  endfunction

  function automatic grid_t shift_left(input grid_t g, input int cols);
    return (g >> 1) & ~col_mask(cols, cols - 1);
  endfunction

  function automatic grid_t shift_right(input grid_t g, input int cols);
    return (g << 1) & ~col_mask(cols, 0);
  endfunction

  function automatic logic row_full(input grid_t g, input int cols, input int row);
    grid_t m;
    m = row_mask(cols, row);
    return (g & m) == m;
  endfunction

endpackage

// File: rtl/tetris_line_clear.sv
// Row scanner for line clearing: tests one row per cycle from the bottom up,
// collapses full rows and keeps the saturating lines_cleared count.
module tetris_line_clear
  import tetris_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   inc,
  input  logic [ROWS*COLS-1:0]   stored_i,
  output logic [ROWS*COLS-1:0]   stored_o,
  output logic                   done,
  output logic [LINE_W-1:0]      lines_cleared
);

  localparam int CELLS = ROWS * COLS;
  localparam int RW    = $clog2(ROWS);

  logic [RW-1:0]     row_q, row_d;
  logic [LINE_W-1:0] count_q, count_d;
  logic              full;
  logic [CELLS-1:0]  low_mask, high_mask, collapsed;

  // A full row stays under the scan pointer so the row that drops into it is tested next.
  always_comb begin
    row_d     = row_q;
    count_d   = count_q;
    stored_o  = stored_i;
    done      = 1'b0;
    full      = row_full(grid_t'(stored_i), COLS, int'(row_q));
    low_mask  = ~({CELLS{1'b1}} << (int'(row_q) * COLS));
    high_mask = {CELLS{1'b1}} << ((int'(row_q) + 1) * COLS);
    collapsed = (stored_i & high_mask) | ((stored_i & low_mask) << COLS);
    if (start) begin
      row_d = RW'(ROWS - 1);
    end else if (inc) begin
      if (full) begin
        stored_o = collapsed;
        if (count_q != '1) count_d = count_q + 1'b1;
      end else if (row_q == '0) begin
        done = 1'b1;
      end else begin
        row_d = row_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q   <= RW'(ROWS - 1);
      count_q <= '0;
    end else begin
      row_q   <= row_d;
      count_q <= count_d;
    end
  end

  assign lines_cleared = count_q;

endmodule

// File: rtl/tetris_game_ctrl.sv
// Playfield controller: owns the active piece and stored grid, runs the
// spawn/fall/lock/clear/over state machine and composes the display.
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drop_tick,
  input  logic                 move_left,
  input  logic                 move_right,
  output logic                 spawn_req,
  input  logic                 piece_valid,
  input  logic [ROWS*COLS-1:0] piece_array,
  output logic [ROWS*COLS-1:0] display_array,
  output logic                 lock_pulse,
  output logic [LINE_W-1:0]    lines_cleared,
  output logic                 game_over
);

  localparam int CELLS = ROWS * COLS;

  game_state_e      state_q, state_d;
  logic [CELLS-1:0] active_q, active_d, stored_q, stored_d, clr_stored;
  logic [CELLS-1:0] down_g, left_g, right_g;
  logic             down_ok, left_ok, right_ok;
  logic             clr_start, clr_inc, clr_done;

  tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .LINE_W(LINE_W)) u_clear (
    .clk          (clk),
    .reset        (reset),
    .start        (clr_start),
    .inc          (clr_inc),
    .stored_i     (stored_q),
    .stored_o     (clr_stored),
    .done         (clr_done),
    .lines_cleared(lines_cleared)
  );

  // Edge checks catch pieces that would fall off the grid or wrap into the next row.
  always_comb begin
    down_g   = CELLS'(shift_down(grid_t'(active_q), COLS));
    left_g   = CELLS'(shift_left(grid_t'(active_q), COLS));
    right_g  = CELLS'(shift_right(grid_t'(active_q), COLS));
    down_ok  = ((active_q & CELLS'(row_mask(COLS, ROWS - 1))) == '0) && ((down_g & stored_q) == '0);
    left_ok  = ((active_q & CELLS'(col_mask(COLS, 0))) == '0) && ((left_g & stored_q) == '0);
    right_ok = ((active_q & CELLS'(col_mask(COLS, COLS - 1))) == '0) && ((right_g & stored_q) == '0);
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    stored_d  = stored_q;
    clr_start = 1'b0;
    clr_inc   = 1'b0;
    case (state_q)
      SPAWN: begin
        if (piece_valid) begin
          if ((piece_array & stored_q) != '0) begin
            active_d = '0;
            state_d  = OVER;
          end else begin
            active_d = piece_array;
            state_d  = FALL;
          end
        end
      end
      FALL: begin
        if (drop_tick) begin
          if (down_ok) active_d = down_g;
          else         state_d  = LOCK;
        end else if (move_left && !move_right) begin
          if (left_ok) active_d = left_g;
        end else if (move_right && !move_left) begin
          if (right_ok) active_d = right_g;
        end
      end
      LOCK: begin
        stored_d  = stored_q | active_q;
        active_d  = '0;
        clr_start = 1'b1;
        state_d   = CLEAR;
      end
      CLEAR: begin
        clr_inc  = 1'b1;
        stored_d = clr_stored;
        if (clr_done) state_d = SPAWN;
      end
      OVER: ;
      default: state_d = SPAWN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SPAWN;
      active_q <= '0;
      stored_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      stored_q <= stored_d;
    end
  end

  assign spawn_req     = (state_q == SPAWN);
  assign lock_pulse    = (state_q == LOCK);
  assign game_over     = (state_q == OVER);
  assign display_array = stored_q | active_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Bench for tetris_game_ctrl: directed scenarios then random play, every cycle
// compared against a cell-array reference model of the game rules.
module tb_tetris_game_ctrl;

  localparam int ROWS   = 22;
  localparam int COLS   = 10;
  localparam int LINE_W = 16;
  localparam int CELLS  = ROWS * COLS;

  localparam int M_SPAWN = 0;
  localparam int M_FALL  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_CLEAR = 3;
  localparam int M_OVER  = 4;

  logic              clk = 1'b0;
  logic              reset, drop_tick, move_left, move_right, piece_valid;
  logic [CELLS-1:0]  piece_array, display_array;
  logic              spawn_req, lock_pulse, game_over;
  logic [LINE_W-1:0] lines_cleared;

  int               assert_cnt = 0;
  int               fail_cnt   = 0;
  logic [CELLS-1:0] m_stored, m_active;
  int               m_st, m_scan, m_lines;

  tetris_game_ctrl #(.ROWS(ROWS), .COLS(COLS), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .drop_tick    (drop_tick),
    .move_left    (move_left),
    .move_right   (move_right),
    .spawn_req    (spawn_req),
    .piece_valid  (piece_valid),
    .piece_array  (piece_array),
    .display_array(display_array),
    .lock_pulse   (lock_pulse),
    .lines_cleared(lines_cleared),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  function automatic int idx(input int r, input int c);
    return r * COLS + c;
  endfunction

  function automatic logic [CELLS-1:0] rect(input int r0, input int r1, input int c0, input int c1);
    logic [CELLS-1:0] g;
    g = '0;
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) g[idx(r, c)] = 1'b1;
    return g;
  endfunction

  function automatic logic [CELLS-1:0] make_piece(input int kind, input int col);
    case (kind)
      0:       return rect(0, 1, col, col + 1);
      1:       return rect(0, 0, col, col + 3);
      2:       return rect(0, 0, col, col + 2) | rect(1, 1, col + 1, col + 1);
      3:       return rect(0, 0, col + 1, col + 2) | rect(1, 1, col, col + 1);
      default: return rect(0, 1, col, col);
    endcase
  endfunction

  task automatic model_reset();
    m_stored = '0;
    m_active = '0;
    m_st     = M_SPAWN;
    m_scan   = ROWS - 1;
    m_lines  = 0;
  endtask

  // Reference rules: a move succeeds only if every cell lands inside the grid on an empty cell.
  task automatic model_step(input logic pv, input logic [CELLS-1:0] pa, input logic dt,
                            input logic ml, input logic mr);
    logic [CELLS-1:0] moved;
    bit ok, full;
    int dr, dc, nr, nc;
    case (m_st)
      M_SPAWN: if (pv) begin
        if ((pa & m_stored) != '0) begin m_active = '0; m_st = M_OVER; end
        else begin m_active = pa; m_st = M_FALL; end
      end
      M_FALL: if (dt || (ml != mr)) begin
        dr = dt ? 1 : 0;
        dc = dt ? 0 : (ml ? -1 : 1);
        ok = 1;
        moved = '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (m_active[idx(r, c)]) begin
              nr = r + dr;
              nc = c + dc;
              if (nr >= ROWS || nc < 0 || nc >= COLS) ok = 0;
              else if (m_stored[idx(nr, nc)]) ok = 0;
              else moved[idx(nr, nc)] = 1'b1;
            end
        if (ok) m_active = moved;
        else if (dt) m_st = M_LOCK;
      end
      M_LOCK: begin
        m_stored = m_stored | m_active;
        m_active = '0;
        m_scan   = ROWS - 1;
        m_st     = M_CLEAR;
      end
      M_CLEAR: begin
        full = 1;
        for (int c = 0; c < COLS; c++) if (!m_stored[idx(m_scan, c)]) full = 0;
        if (full) begin
          for (int r = m_scan; r > 0; r--)
            for (int c = 0; c < COLS; c++) m_stored[idx(r, c)] = m_stored[idx(r - 1, c)];
          for (int c = 0; c < COLS; c++) m_stored[idx(0, c)] = 1'b0;
          if (m_lines < (1 << LINE_W) - 1) m_lines++;
        end else if (m_scan == 0) begin
          m_st = M_SPAWN;
        end else begin
          m_scan--;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("spawn_req", CELLS'(spawn_req), CELLS'(m_st == M_SPAWN));
    check("display", display_array, m_stored | m_active);
    check("lock_pulse", CELLS'(lock_pulse), CELLS'(m_st == M_LOCK));
    check("lines", CELLS'(lines_cleared), CELLS'(m_lines));
    check("game_over", CELLS'(game_over), CELLS'(m_st == M_OVER));
    check("overlap", dut.active_q & dut.stored_q, '0);
  endtask

  task automatic apply_stimulus(input logic pv, input logic [CELLS-1:0] pa, input logic dt,
                                input logic ml, input logic mr);
    piece_valid = pv;
    piece_array = pa;
    drop_tick   = dt;
    move_left   = ml;
    move_right  = mr;
    @(posedge clk);
    model_step(pv, pa, dt, ml, mr);
    #1;
    check_output();
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_output();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_spawn();
    int k;
    k = 0;
    while (!spawn_req && k < 100) begin idle(); k++; end
    check("spawn_wait", CELLS'(spawn_req), CELLS'(1));
  endtask

  task automatic drop_until_lock();
    int k;
    k = 0;
    while (!lock_pulse && k < 40) begin apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0); k++; end
    check("lock_wait", CELLS'(lock_pulse), CELLS'(1));
  endtask

  task automatic land(input logic [CELLS-1:0] pa);
    apply_stimulus(1'b1, pa, 1'b0, 1'b0, 1'b0);
    drop_until_lock();
    wait_spawn();
  endtask

  initial begin
    int over_cycles;
    reset = 1'b1; drop_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
    piece_valid = 1'b0; piece_array = '0;
    model_reset();
    #1;
    check_output();
    @(negedge clk);
    reset = 1'b0;

    // Spawn an O-piece, let it fall to the floor and lock
    apply_stimulus(1'b1, rect(0, 1, 4, 5), 1'b0, 1'b0, 1'b0);
    check("spawn_drop", CELLS'(spawn_req), CELLS'(0));
    check("o_spawn", display_array, rect(0, 1, 4, 5));
    repeat (20) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("o_floor", display_array, rect(20, 21, 4, 5));
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("o_lock", CELLS'(lock_pulse), CELLS'(1));
    idle();
    check("o_lock_end", CELLS'(lock_pulse), CELLS'(0));
    wait_spawn();
    check("o_stored", display_array, rect(20, 21, 4, 5));

    // Single and double line clears, with rows above collapsing
    do_reset();
    land(rect(0, 0, 0, 7));
    land(rect(0, 1, 8, 9));
    check("one_line", CELLS'(lines_cleared), CELLS'(1));
    check("collapse", display_array, rect(21, 21, 8, 9));
    land(rect(0, 0, 0, 7));
    check("two_lines", CELLS'(lines_cleared), CELLS'(2));
    land(rect(0, 1, 0, 7));
    land(rect(0, 1, 8, 9));
    check("double_clear", CELLS'(lines_cleared), CELLS'(4));
    check("empty_grid", display_array, '0);

    // Lateral moves at the left wall and drop priority
    apply_stimulus(1'b1, rect(0, 1, 0, 0), 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("left_wall", display_array, rect(0, 1, 0, 0));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("right_move", display_array, rect(0, 1, 1, 1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("both_moves", display_array, rect(0, 1, 1, 1));
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("drop_prio", display_array, rect(1, 2, 1, 1));
    repeat (9) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("right_wall", display_array, rect(1, 2, 9, 9));

    // Reset mid-FALL
    do_reset();

    // Game over when the spawn overlaps the stack
    land(rect(0, 20, 3, 6));
    apply_stimulus(1'b1, rect(1, 1, 3, 6), 1'b0, 1'b0, 1'b0);
    check("game_over", CELLS'(game_over), CELLS'(1));
    check("over_no_req", CELLS'(spawn_req), CELLS'(0));
    repeat (5) apply_stimulus(1'b1, rect(0, 0, 0, 3), 1'b1, 1'b1, 1'b0);
    check("over_frozen", display_array, rect(1, 21, 3, 6));

    // Reset while a full row is waiting in CLEAR
    do_reset();
    land(rect(0, 0, 0, 9));
    apply_stimulus(1'b1, rect(0, 0, 0, 9), 1'b0, 1'b0, 1'b0);
    drop_until_lock();
    idle();
    do_reset();
    check("clear_reset_lines", CELLS'(lines_cleared), CELLS'(0));
    check("clear_reset_grid", display_array, '0);

    // Random play
    over_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      int kind, w;
      kind = int'($urandom_range(0, 4));
      w = (kind == 0) ? 2 : (kind == 1) ? 4 : (kind == 4) ? 1 : 3;
      apply_stimulus(($urandom % 4) == 0, make_piece(kind, int'($urandom_range(0, COLS - w))),
                     ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0);
      if (m_st == M_OVER) over_cycles++;
      if (over_cycles > 10) begin
        do_reset();
        over_cycles = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
